// File: rtl/mda_motor_control_ramp.sv
// Duty-cycle slew limiter in front of the per-motor PWM generator.
// Moves duty_cycle toward the commanded target by at most STEP per update
// tick, forces direction reversals through a dwell at half-period, and drops
// the motor to drift if the command stream goes quiet for too long.
module mda_motor_control_ramp #(
  parameter int PERIOD_LENGTH = 16,
  parameter int STEP          = 16,
  parameter int UPDATE_DIV    = 1600,
  parameter int REV_DWELL     = 8,
  parameter int WD_TIMEOUT    = 16000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PERIOD_LENGTH-1:0] period,
  input  logic                     cmd_valid,
  input  logic [PERIOD_LENGTH-1:0] cmd_duty,
  input  logic                     cmd_on,
  output logic [PERIOD_LENGTH-1:0] duty_cycle,
  output logic                     on,
  output logic                     at_target,
  output logic                     wd_tripped
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int PRE_W = $clog2(UPDATE_DIV);
  localparam int DW_W  = (REV_DWELL > 1) ? $clog2(REV_DWELL) : 1;

  localparam logic [PRE_W-1:0]         PRE_LAST = PRE_W'(UPDATE_DIV - 1);
  localparam logic [DW_W-1:0]          DW_LAST  = DW_W'(REV_DWELL - 1);
  localparam logic [31:0]              WD_LAST  = 32'(WD_TIMEOUT - 1);
  localparam logic [PERIOD_LENGTH-1:0] STEP_V   = PERIOD_LENGTH'(STEP);

  // Saturate a value to an upper limit (used for the period clamp).
  function automatic logic [PERIOD_LENGTH-1:0] clamp_to(
    input logic [PERIOD_LENGTH-1:0] x,
    input logic [PERIOD_LENGTH-1:0] lim
  );
    return (x > lim) ? lim : x;
  endfunction

  // Side of the centre point: +1 forward, -1 reverse, 0 exactly centred.
  function automatic logic signed [1:0] side_of(
    input logic [PERIOD_LENGTH-1:0] x,
    input logic [PERIOD_LENGTH-1:0] half
  );
    if (x > half)      return 2'sd1;
    else if (x < half) return -2'sd1;
    else               return 2'sd0;
  endfunction

  // One bounded slew step from cur toward goal; lands exactly on goal when
  // within STEP so the ramp can never overshoot or wrap.
  function automatic logic [PERIOD_LENGTH-1:0] step_toward(
    input logic [PERIOD_LENGTH-1:0] cur,
    input logic [PERIOD_LENGTH-1:0] goal
  );
    if (goal > cur) return ((goal - cur) > STEP_V) ? (cur + STEP_V) : goal;
    else            return ((cur - goal) > STEP_V) ? (cur - STEP_V) : goal;
  endfunction

  logic [1:0]               state, state_n;
  logic [PERIOD_LENGTH-1:0] target, tgt_n, duty_n;
  logic                     on_n, at_n, wd_n;
  logic [PRE_W-1:0]         pre_cnt, pre_n;
  logic [31:0]              wd_cnt, wdc_n;
  logic [DW_W-1:0]          dwell_cnt, dw_n;
  logic                     from_above, from_n;

  logic [PERIOD_LENGTH-1:0] half, duty_c, tgt_c, cmd_tgt, eff, stepped;
  logic signed [1:0]        sd, st;
  logic                     tick, rev, pending_cmd;

  // Next-state logic: command > watchdog trip > per-state ramp behaviour.
  always_comb begin
    half        = period >> 1;
    duty_c      = clamp_to(duty_cycle, period);
    tgt_c       = clamp_to(target, period);
    cmd_tgt     = clamp_to(cmd_duty, period);
    tick        = (pre_cnt == PRE_LAST);
    sd          = side_of(duty_c, half);
    st          = side_of(tgt_c, half);
    rev         = (sd != 2'sd0) && (st != 2'sd0) && (sd != st);
    eff         = rev ? half : tgt_c;
    stepped     = step_toward(duty_c, eff);
    // While dwelling the duty sits at half, so the direction we came from
    // is remembered to decide whether a new command still needs the dwell.
    pending_cmd = from_above ? (cmd_tgt < half) : (cmd_tgt > half);

    state_n = state;
    duty_n  = duty_c;
    tgt_n   = tgt_c;
    on_n    = on;
    wd_n    = wd_tripped;
    pre_n   = tick ? '0 : pre_cnt + 1'b1;
    wdc_n   = on ? wd_cnt + 32'd1 : wd_cnt;
    dw_n    = dwell_cnt;
    from_n  = from_above;

    if (cmd_valid) begin
      tgt_n = cmd_tgt;
      pre_n = '0;
      wdc_n = '0;
      wd_n  = 1'b0;
      if (cmd_on) begin
        on_n = 1'b1;
        if (state == S_IDLE) duty_n = half;
        if ((state == S_DWELL) && pending_cmd) begin
          duty_n = half;
        end else begin
          state_n = S_RAMP;
          dw_n    = '0;
        end
      end else begin
        on_n    = 1'b0;
        duty_n  = half;
        state_n = S_IDLE;
      end
    end else if (on && (wd_cnt == WD_LAST)) begin
      on_n    = 1'b0;
      duty_n  = half;
      state_n = S_IDLE;
      wd_n    = 1'b1;
      wdc_n   = '0;
    end else begin
      case (state)
        S_IDLE: duty_n = half;
        S_RAMP: begin
          if (tick) begin
            duty_n = stepped;
            if (rev && (stepped == half)) begin
              state_n = S_DWELL;
              dw_n    = '0;
              from_n  = (sd == 2'sd1);
            end else if (stepped == tgt_c) begin
              state_n = S_HOLD;
            end
          end
        end
        S_DWELL: begin
          duty_n = half;
          if (tick) begin
            if (dwell_cnt == DW_LAST) begin
              state_n = S_RAMP;
              dw_n    = '0;
            end else begin
              dw_n = dwell_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    at_n = (state_n == S_HOLD);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      duty_cycle <= '0;
      on         <= 1'b0;
      at_target  <= 1'b0;
      wd_tripped <= 1'b0;
      pre_cnt    <= '0;
      wd_cnt     <= '0;
      dwell_cnt  <= '0;
    end else begin
      state      <= state_n;
      duty_cycle <= duty_n;
      on         <= on_n;
      at_target  <= at_n;
      wd_tripped <= wd_n;
      pre_cnt    <= pre_n;
      wd_cnt     <= wdc_n;
      dwell_cnt  <= dw_n;
    end
  end

  // Latched target and dwell direction; only consulted outside IDLE.
  always_ff @(posedge clk) begin
    target     <= tgt_n;
    from_above <= from_n;
  end

endmodule

// File: tb/tb_mda_motor_control_ramp.sv
// Bench for mda_motor_control_ramp: directed scenarios plus random command
// traffic, scored every cycle against a behavioural model of the ramp.
module tb_mda_motor_control_ramp;

  localparam int P_STEP  = 100;
  localparam int P_DIV   = 10;
  localparam int P_DWELL = 3;
  localparam int P_WD    = 1000;

  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_DWELL = 2;
  localparam int M_HOLD  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] period = 16'd1000;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_duty = 16'd0;
  logic        cmd_on = 1'b0;
  logic [15:0] duty_cycle;
  logic        on;
  logic        at_target;
  logic        wd_tripped;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] duty;
    logic        on;
    logic        at;
    logic        wd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Behavioural model state
  int m_duty = 0, m_tgt = 0, m_mode = M_IDLE, m_age = 0, m_oncyc = 0, m_dticks = 0;
  bit m_on = 0, m_at = 0, m_wd = 0, m_above = 0;

  mda_motor_control_ramp #(
    .PERIOD_LENGTH(16),
    .STEP(P_STEP),
    .UPDATE_DIV(P_DIV),
    .REV_DWELL(P_DWELL),
    .WD_TIMEOUT(P_WD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .period(period),
    .cmd_valid(cmd_valid),
    .cmd_duty(cmd_duty),
    .cmd_on(cmd_on),
    .duty_cycle(duty_cycle),
    .on(on),
    .at_target(at_target),
    .wd_tripped(wd_tripped)
  );

  always #5 clk = ~clk;

  // Predict the outputs after the coming clock edge and queue them.
  function automatic void model_step(input bit r, input bit v, input int cd, input bit co, input int p);
    int  half, d, t, eff, delta;
    bit  tick, rev;
    half = p / 2;
    if (r) begin
      m_duty = 0; m_on = 0; m_at = 0; m_wd = 0;
      m_mode = M_IDLE; m_age = 0; m_oncyc = 0; m_dticks = 0;
      exp_q.push_back({16'(m_duty), m_on, m_at, m_wd});
      return;
    end
    d    = (m_duty > p) ? p : m_duty;
    t    = (m_tgt > p) ? p : m_tgt;
    tick = ((m_age % P_DIV) == P_DIV - 1);
    if (v) begin
      t = (cd > p) ? p : cd;
      m_age = 0; m_oncyc = 0; m_wd = 0;
      if (!co) begin
        m_on = 0; d = half; m_mode = M_IDLE;
      end else begin
        m_on = 1;
        if (m_mode == M_IDLE) d = half;
        if (m_mode == M_DWELL && (m_above ? (t < half) : (t > half))) d = half;
        else begin
          m_mode = M_RAMP; m_dticks = 0;
        end
      end
    end else if (m_on && (m_oncyc + 1 >= P_WD)) begin
      m_on = 0; d = half; m_mode = M_IDLE; m_wd = 1; m_oncyc = 0;
      m_age++;
    end else begin
      m_age++;
      if (m_on) m_oncyc++;
      case (m_mode)
        M_IDLE: d = half;
        M_RAMP: if (tick) begin
          rev   = ((d - half) * (t - half)) < 0;
          eff   = rev ? half : t;
          delta = eff - d;
          if (delta > P_STEP)  delta = P_STEP;
          if (delta < -P_STEP) delta = -P_STEP;
          if (rev) m_above = (d > half);
          d = d + delta;
          if (rev && d == half) begin
            m_mode = M_DWELL; m_dticks = 0;
          end else if (d == t) begin
            m_mode = M_HOLD;
          end
        end
        M_DWELL: begin
          d = half;
          if (tick) begin
            m_dticks++;
            if (m_dticks == P_DWELL) begin
              m_mode = M_RAMP; m_dticks = 0;
            end
          end
        end
        default: ;
      endcase
    end
    m_duty = d;
    m_tgt  = t;
    m_at   = (m_mode == M_HOLD);
    exp_q.push_back({16'(m_duty), m_on, m_at, m_wd});
  endfunction

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({duty_cycle, on, at_target, wd_tripped} !== mon_e) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got duty=%0d on=%0b at=%0b wd=%0b, expected duty=%0d on=%0b at=%0b wd=%0b",
                 $time, duty_cycle, on, at_target, wd_tripped, mon_e.duty, mon_e.on, mon_e.at, mon_e.wd);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One clock: drive inputs, predict, let the edge happen, return at negedge.
  task automatic cyc(input bit r, input bit v, input int cd, input bit co);
    reset     = r;
    cmd_valid = v;
    cmd_duty  = 16'(cd);
    cmd_on    = co;
    model_step(r, v, cd, co, int'(period));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    // Reset held three cycles
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_on", on, 0);
    chk("rst_at", at_target, 0);
    chk("rst_wd", wd_tripped, 0);
    cyc(0, 0, 0, 0);
    chk("release_duty", duty_cycle, 500);
    chk("release_on", on, 0);

    // Forward ramp 500 -> 800
    cyc(0, 1, 800, 1);
    chk("fwd_on_n1", on, 1);
    chk("fwd_duty_n1", duty_cycle, 500);
    idle(9);  chk("fwd_duty_n10", duty_cycle, 500);
    idle(1);  chk("fwd_duty_n11", duty_cycle, 600);
    idle(10); chk("fwd_duty_n21", duty_cycle, 700);
    chk("fwd_at_n21", at_target, 0);
    idle(10); chk("fwd_duty_n31", duty_cycle, 800);
    chk("fwd_at_n31", at_target, 1);

    // Reversal 800 -> 250 through the dwell
    cyc(0, 1, 250, 1);
    chk("rev_at_cleared", at_target, 0);
    idle(30); chk("rev_duty_half", duty_cycle, 500);
    idle(30); chk("rev_dwell_hold", duty_cycle, 500);
    idle(10); chk("rev_duty_400", duty_cycle, 400);
    chk("rev_on", on, 1);
    idle(20); chk("rev_duty_250", duty_cycle, 250);
    chk("rev_at", at_target, 1);

    // Watchdog trip 1000 cycles after the last command
    idle(909); chk("wd_before_on", on, 1);
    idle(1);
    chk("wd_trip_on", on, 0);
    chk("wd_trip_duty", duty_cycle, 500);
    chk("wd_trip_flag", wd_tripped, 1);
    cyc(0, 1, 300, 1);
    chk("wd_clear_flag", wd_tripped, 0);

    // Drift command mid-ramp at 650
    cyc(0, 1, 550, 1); idle(10);
    chk("mid_hold_550", duty_cycle, 550);
    cyc(0, 1, 1000, 1); idle(10);
    chk("mid_duty_650", duty_cycle, 650);
    cyc(0, 1, 0, 0);
    chk("drift_on", on, 0);
    chk("drift_duty", duty_cycle, 500);

    // Target above period is clamped
    cyc(0, 1, 1200, 1); idle(50);
    chk("clamp_duty", duty_cycle, 1000);
    chk("clamp_at", at_target, 1);
    idle(20); chk("clamp_stays", duty_cycle, 1000);

    // Period shrink re-clamps the held duty
    period = 16'd800; idle(1);
    chk("shrink_duty", duty_cycle, 800);
    period = 16'd1000; idle(1);
    chk("shrink_keep", duty_cycle, 800);

    // Reset mid-ramp
    cyc(0, 1, 200, 1); idle(15);
    chk("pre_reset_duty", duty_cycle, 700);
    cyc(1, 0, 0, 0);
    chk("midrst_duty", duty_cycle, 0);
    chk("midrst_on", on, 0);
    cyc(0, 0, 0, 0);
    chk("midrst_release", duty_cycle, 500);

    // Random command traffic
    for (int k = 0; k < 300; k++) begin
      int sel;
      int cd;
      int pick;
      bit co;
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        cyc(1, 0, 0, 0);
      end else if (sel < 7) begin
        idle(P_WD + 20);
      end else begin
        pick = $urandom_range(0, 9);
        if (pick < 4)      cd = $urandom_range(0, 1300);
        else if (pick < 7) cd = $urandom_range(380, 620);
        else if (pick < 8) cd = 500;
        else if (pick < 9) cd = $urandom_range(0, 150);
        else               cd = $urandom_range(850, 1100);
        co = ($urandom_range(0, 9) != 0);
        cyc(0, 1, cd, co);
        idle($urandom_range(0, 80));
      end
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
